gt_compare_sequencer: RTL and testbench

- Multi-cycle magnitude comparator controller for the Kolache ALU.
- Reuses one SLICE-bit greater-than/equal evaluation per cycle, walking latched WIDTH-bit operands from the most-significant slice down.
- Terminates early on the first unequal slice and reports gt/eq/lt with a start/done handshake.
- Sits beside the ALU result mux; the ALU control issues start and waits for done.

---
 rtl/gt_compare_sequencer_if.sv | 30 +++
 rtl/gt_compare_sequencer.sv | 117 +++++++++++
 tb/tb_gt_compare_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gt_compare_sequencer_if.sv
// Start/done handshake bundle between the ALU control and the comparator.
// master: start, signed_mode, a, b; slave: busy, done, gt, eq, lt, cycles.
interface gt_compare_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = $clog2(NSLICE) + 1;

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [CW-1:0]    cycles;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, gt, eq, lt, cycles
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, gt, eq, lt, cycles
    );
endinterface

// File: rtl/gt_compare_sequencer.sv
// Multi-cycle magnitude comparator: walks SLICE-bit slices MSB-first.
// Ports: clk, rst (async high), bus (slave: start/operands in, result out).
module gt_compare_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input logic                   clk,
    input logic                   rst,
    gt_compare_sequencer_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = $clog2(NSLICE) + 1;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] TOP = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t state;

    logic [NSLICE-1:0][SLICE-1:0] a_q;
    logic [NSLICE-1:0][SLICE-1:0] b_q;
    logic                         sm_q;
    logic [IW-1:0]                idx;
    logic [CW-1:0]                cyc_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         gt_q;
    logic                         eq_q;
    logic                         lt_q;

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;

    // Flipping the sign bit of the top slice maps two's-complement
    // ordering onto unsigned ordering for that slice only.
    always_comb begin
        sa = a_q[idx];
        sb = b_q[idx];
        if (sm_q && (idx == TOP)) begin
            sa[SLICE-1] = ~sa[SLICE-1];
            sb[SLICE-1] = ~sb[SLICE-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sm_q   <= 1'b0;
            idx    <= '0;
            cyc_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            gt_q   <= 1'b0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        sm_q   <= bus.signed_mode;
                        idx    <= TOP;
                        cyc_q  <= '0;
                        gt_q   <= 1'b0;
                        eq_q   <= 1'b0;
                        lt_q   <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    cyc_q <= cyc_q + CW'(1);
                    if (sa != sb) begin
                        gt_q   <= (sa > sb);
                        lt_q   <= (sa < sb);
                        eq_q   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (idx == '0) begin
                        gt_q   <= 1'b0;
                        lt_q   <= 1'b0;
                        eq_q   <= 1'b1;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.gt     = gt_q;
    assign bus.eq     = eq_q;
    assign bus.lt     = lt_q;
    assign bus.cycles = cyc_q;
endmodule

// File: tb/tb_gt_compare_sequencer.sv
// Directed and randomized checks of gt_compare_sequencer
// against an arithmetic reference model.
module tb_gt_compare_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    gt_compare_sequencer_if #(.WIDTH(32), .SLICE(4)) bus ();

    gt_compare_sequencer #(.WIDTH(32), .SLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word compare; cycles = slices down to the
    // highest differing bit (all 8 when equal).
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  input logic sm, output logic g,
                                  output logic e, output logic l,
                                  output int cyc);
        logic [31:0] d;
        int          hi;
        if (sm) begin
            g = $signed(x) > $signed(y);
            l = $signed(x) < $signed(y);
        end else begin
            g = x > y;
            l = x < y;
        end
        e  = (x == y);
        d  = x ^ y;
        hi = -1;
        for (int i = 0; i < 32; i++)
            if (d[i]) hi = i;
        cyc = (hi < 0) ? 8 : 8 - hi / 4;
    endfunction

    task automatic do_cmp(input logic [31:0] ta, input logic [31:0] tb2,
                          input logic sm, input string tag);
        logic g, e, l;
        int   cyc;
        int   n;
        model(ta, tb2, sm, g, e, l, cyc);
        @(negedge clk);
        bus.a           = ta;
        bus.b           = tb2;
        bus.signed_mode = sm;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.a           = $urandom;
        bus.b           = $urandom;
        bus.signed_mode = 1'($urandom);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, cyc);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_gt"}, 32'(bus.gt), 32'(g));
        chk({tag, "_eq"}, 32'(bus.eq), 32'(e));
        chk({tag, "_lt"}, 32'(bus.lt), 32'(l));
        chk({tag, "_cyc"}, 32'(bus.cycles), cyc);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hold"}, {bus.gt, bus.eq, bus.lt}, {g, e, l});
    endtask

    initial begin
        int          n;
        int          dn;
        int          ndone;
        logic [31:0] ra;
        logic [31:0] rb;
        int          k;

        bus.start       = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res", {bus.gt, bus.eq, bus.lt}, 32'd0);
        chk("rst_cyc", 32'(bus.cycles), 32'd0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b0, "u_early");
        do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b1, "s_early");
        do_cmp(32'h12345678, 32'h12345678, 1'b0, "eq_walk");
        do_cmp(32'h00000000, 32'h00000000, 1'b0, "eq_zero");
        do_cmp(32'h00000011, 32'h00000010, 1'b0, "last_gt");
        do_cmp(32'h00000010, 32'h00000011, 1'b0, "last_lt");
        do_cmp(32'hFFFFFFFF, 32'h00000001, 1'b1, "s_mixed");
        do_cmp(32'hFFFFFFFF, 32'h00000001, 1'b0, "u_mixed");

        // Starts pulsed at edges 3 and 9 must be ignored.
        @(negedge clk);
        bus.a           = 32'h0000000F;
        bus.b           = 32'h0000000E;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dn        = 0;
        ndone     = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 3 || i == 9) begin
                bus.start       = 1'b1;
                bus.a           = $urandom;
                bus.b           = $urandom;
                bus.signed_mode = 1'($urandom);
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (dn == 0) dn = i;
            end
        end
        chk("hs_lat", dn, 8);
        chk("hs_ndone", ndone, 1);
        chk("hs_gt", {bus.gt, bus.eq, bus.lt}, 32'b100);
        chk("hs_cyc", 32'(bus.cycles), 32'd8);
        chk("hs_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a full walk.
        @(negedge clk);
        bus.a     = 32'h12345678;
        bus.b     = 32'h12345678;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done", 32'(bus.done), 32'd0);
        chk("ar_res", {bus.gt, bus.eq, bus.lt}, 32'd0);
        chk("ar_cyc", 32'(bus.cycles), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("ar_nodone", ndone, 0);
        do_cmp(32'h0000000F, 32'h0000000E, 1'b0, "ar_after");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            k  = $urandom_range(0, 3);
            unique case (k)
                0: rb = $urandom;
                1: rb = ra;
                2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
                default: begin
                    n  = $urandom_range(1, 31);
                    rb = $urandom;
                    rb = (ra & ~((32'd1 << n) - 1)) | (rb & ((32'd1 << n) - 1));
                end
            endcase
            do_cmp(ra, rb, 1'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
